vram_console_ctrl: RTL and testbench

//  Text-console controller in front of the 90x30 HDMI text VRAM (16-bit cells, {attr[7:0],char[7:0]}).
//  CPU writes bytes over the simple a/d/we/spo bus; block queues them and sequences VRAM writes.

---
 rtl/vram_console_ctrl_if.sv | 18 +
 rtl/vram_console_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_vram_console_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_console_ctrl_if.sv
// CPU register bus seen by the console controller.
// Read data comes back registered one cycle after the address.
interface vram_console_ctrl_if;
  logic [31:0] a;
  logic [31:0] d;
  logic        we;
  logic [31:0] spo;

  modport master (
    output a, d, we,
    input  spo
  );

  modport slave (
    input  a, d, we,
    output spo
  );
endinterface

// File: rtl/vram_console_ctrl.sv
// Text console in front of the HDMI text VRAM: char queue, cursor, scroll.
// Build macro VCON_CLS_ON_RESET_EN: clear the whole screen after reset.
module vram_console_ctrl #(
  parameter int          COLS         = 90,
  parameter int          ROWS         = 30,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [7:0]  ATTR_DEFAULT = 8'h07
) (
  input  logic                      clk,
  input  logic                      rst,
  vram_console_ctrl_if.slave        bus,
  output logic                      vram_we,
  output logic [11:0]               vram_a,
  output logic [15:0]               vram_d,
  output logic [4:0]                scroll_base,
  output logic                      busy
);

  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH     = (PW+1)'(FIFO_DEPTH);
  localparam logic [6:0]  COL_LAST  = 7'(COLS-1);
  localparam logic [4:0]  ROW_LAST  = 5'(ROWS-1);
  localparam logic [5:0]  ROWS6     = 6'(ROWS);
  localparam logic [11:0] COLS12    = 12'(COLS);
  localparam logic [11:0] CELL_LAST = 12'(COLS*ROWS-1);

  typedef enum logic [1:0] {
    IDLE,
    CLR_LINE,
    CLR_ALL
  } state_t;

  state_t        state;
  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          full;
  logic          empty;
  logic          tx_wr;
  logic          push;
  logic          pop;
  logic          ovf;
  logic [7:0]    attr;
  logic [4:0]    row;
  logic [6:0]    col;
  logic [11:0]   clr_idx;
  logic [11:0]   clr_end;
  logic          cls_pend;

  logic [7:0]    ch;
  logic          is_print;
  logic          nl;
  logic          go_cls;
  logic [6:0]    col_n;
  logic [6:0]    tab;
  logic [5:0]    row_sum;
  logic [4:0]    phys;
  logic [11:0]   cell_a;
  logic [11:0]   sb_base;
  logic [4:0]    sb_next;
  logic          unused_bits;

  assign unused_bits = ^{bus.a[31:4], bus.a[1:0],
                         bus.d[31:8]};

  assign full  = count == DEPTH;
  assign empty = count == '0;
  assign tx_wr = bus.we && bus.a[3:2] == 2'd0;
  assign push  = tx_wr && !full;
  assign pop   = state == IDLE && !empty && !cls_pend;
  assign busy  = !empty || state != IDLE;

  assign row_sum = {1'b0, row} + {1'b0, scroll_base};
  assign phys    = row_sum >= ROWS6 ? 5'(row_sum - ROWS6)
                                    : row_sum[4:0];
  assign cell_a  = 12'(phys) * COLS12 + {5'd0, col};
  assign sb_base = 12'(scroll_base) * COLS12;
  assign sb_next = scroll_base == ROW_LAST ? 5'd0
                                           : scroll_base + 5'd1;
  assign ch       = fifo[rd_ptr];
  assign is_print = ch >= 8'h20;
  assign tab      = (col | 7'd7) + 7'd1;

  // Decode the byte at the FIFO head into cursor motion.
  always_comb begin
    nl     = 1'b0;
    go_cls = 1'b0;
    col_n  = col;
    unique case (1'b1)
      is_print: begin
        if (col == COL_LAST) begin
          col_n = '0;
          nl    = 1'b1;
        end else begin
          col_n = col + 7'd1;
        end
      end
      ch == 8'h0A: begin
        col_n = '0;
        nl    = 1'b1;
      end
      ch == 8'h0D: col_n = '0;
      ch == 8'h08: col_n = col == '0 ? '0 : col - 7'd1;
      ch == 8'h09: begin
        if (tab > COL_LAST) begin
          col_n = '0;
          nl    = 1'b1;
        end else begin
          col_n = tab;
        end
      end
      ch == 8'h0C: go_cls = 1'b1;
      default: ;
    endcase
  end

  // Queue storage; no reset needed, occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= bus.d[7:0];
  end

`ifdef VCON_CLS_ON_RESET_EN
  // One-shot request to blank the screen once reset is released.
  always_ff @(posedge clk) begin
    if (rst) cls_pend <= 1'b1;
    else if (state == IDLE) cls_pend <= 1'b0;
  end
`else
  assign cls_pend = 1'b0;
`endif

  // Registers, queue pointers and read-back path.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      attr    <= ATTR_DEFAULT;
      bus.spo <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (tx_wr && full)
        ovf <= 1'b1;
      else if (bus.we && bus.a[3:2] == 2'd3 && bus.d[2])
        ovf <= 1'b0;
      if (bus.we && bus.a[3:2] == 2'd1)
        attr <= bus.d[7:0];
      unique case (bus.a[3:2])
        2'd1:    bus.spo <= {24'd0, attr};
        2'd2:    bus.spo <= {11'd0, row, 9'd0, col};
        2'd3:    bus.spo <= {29'd0, ovf, busy, full};
        default: bus.spo <= '0;
      endcase
    end
  end

  // Console FSM: pops one byte per cycle in IDLE, blanks cells otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rd_ptr      <= '0;
      row         <= '0;
      col         <= '0;
      scroll_base <= '0;
      clr_idx     <= '0;
      clr_end     <= '0;
      vram_we     <= 1'b0;
      vram_a      <= '0;
      vram_d      <= '0;
    end else begin
      vram_we <= 1'b0;
      case (state)
        IDLE: begin
          if (cls_pend) begin
            state       <= CLR_ALL;
            clr_idx     <= '0;
            clr_end     <= CELL_LAST;
            row         <= '0;
            col         <= '0;
            scroll_base <= '0;
          end else if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (is_print) begin
              vram_we <= 1'b1;
              vram_a  <= cell_a;
              vram_d  <= {attr, ch};
            end
            if (go_cls) begin
              state       <= CLR_ALL;
              clr_idx     <= '0;
              clr_end     <= CELL_LAST;
              row         <= '0;
              col         <= '0;
              scroll_base <= '0;
            end else begin
              col <= col_n;
              if (nl) begin
                if (row != ROW_LAST) begin
                  row <= row + 5'd1;
                end else begin
                  scroll_base <= sb_next;
                  state       <= CLR_LINE;
                  clr_idx     <= sb_base;
                  clr_end     <= sb_base + COLS12 - 12'd1;
                end
              end
            end
          end
        end
        CLR_LINE, CLR_ALL: begin
          vram_we <= 1'b1;
          vram_a  <= clr_idx;
          vram_d  <= {attr, 8'h20};
          if (clr_idx == clr_end) state <= IDLE;
          else clr_idx <= clr_idx + 12'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_console_ctrl.sv
// Directed bench for vram_console_ctrl: vector table plus
// multi-cycle sequences for wrap, scroll, overflow, clear and reset.
module tb_vram_console_ctrl;
  logic        clk;
  logic        rst;
  logic        vram_we;
  logic [11:0] vram_a;
  logic [15:0] vram_d;
  logic [4:0]  scroll_base;
  logic        busy;

  vram_console_ctrl_if bus ();

  vram_console_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .vram_we     (vram_we),
    .vram_a      (vram_a),
    .vram_d      (vram_d),
    .scroll_base (scroll_base),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk;
  int          n_fail;
  int          wr_cnt;
  logic [31:0] log_mem [0:8191];

  // Record every VRAM write seen on the port.
  always @(negedge clk) begin
    if (vram_we === 1'b1) begin
      log_mem[wr_cnt[12:0]] = {4'd0, vram_a, vram_d};
      wr_cnt = wr_cnt + 1;
    end
  end

  typedef struct {
    logic [7:0]  ch;
    logic        we;
    logic [11:0] a;
    logic [15:0] d;
    logic [4:0]  row;
    logic [6:0]  col;
  } vec_t;

  vec_t vt [13];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] c);
    bus.a  = 32'h0;
    bus.d  = {24'd0, c};
    bus.we = 1'b1;
    tick(1);
    bus.we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] ad, input logic [31:0] dt);
    bus.a  = ad;
    bus.d  = dt;
    bus.we = 1'b1;
    tick(1);
    bus.we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] ad, output logic [31:0] v);
    bus.a  = ad;
    bus.we = 1'b0;
    tick(1);
    v = bus.spo;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      tick(1);
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
    tick(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] cur(input int r, input int c);
    return (32'(r) << 16) | 32'(c);
  endfunction

  logic [31:0] v;
  int          s;
  int          blanks;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    wr_cnt = 0;
    bus.a  = '0;
    bus.d  = '0;
    bus.we = 1'b0;
    rst    = 1'b1;

    vt[0]  = '{8'h41, 1'b1, 12'd0,  16'h1F41, 5'd0, 7'd1};
    vt[1]  = '{8'h62, 1'b1, 12'd1,  16'h1F62, 5'd0, 7'd2};
    vt[2]  = '{8'h08, 1'b0, 12'd0,  16'h0000, 5'd0, 7'd1};
    vt[3]  = '{8'h63, 1'b1, 12'd1,  16'h1F63, 5'd0, 7'd2};
    vt[4]  = '{8'h09, 1'b0, 12'd0,  16'h0000, 5'd0, 7'd8};
    vt[5]  = '{8'h5A, 1'b1, 12'd8,  16'h1F5A, 5'd0, 7'd9};
    vt[6]  = '{8'h0D, 1'b0, 12'd0,  16'h0000, 5'd0, 7'd0};
    vt[7]  = '{8'h0A, 1'b0, 12'd0,  16'h0000, 5'd1, 7'd0};
    vt[8]  = '{8'h01, 1'b0, 12'd0,  16'h0000, 5'd1, 7'd0};
    vt[9]  = '{8'h08, 1'b0, 12'd0,  16'h0000, 5'd1, 7'd0};
    vt[10] = '{8'h71, 1'b1, 12'd90, 16'h1F71, 5'd1, 7'd1};
    vt[11] = '{8'hFF, 1'b1, 12'd91, 16'h1FFF, 5'd1, 7'd2};
    vt[12] = '{8'h09, 1'b0, 12'd0,  16'h0000, 5'd1, 7'd8};

    tick(2);
    chk("rst_spo", bus.spo, 32'd0);
    chk("rst_we", {31'd0, vram_we}, 32'd0);
    chk("rst_a", {20'd0, vram_a}, 32'd0);
    chk("rst_d", {16'd0, vram_d}, 32'd0);
    chk("rst_sb", {27'd0, scroll_base}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    rd(32'h4, v); chk("rst_attr", v, 32'h07);
    rd(32'h8, v); chk("rst_cursor", v, 32'h0);
    rd(32'hC, v); chk("rst_status", v, 32'h0);

    wr(32'h4, 32'h1F);
    rd(32'h4, v); chk("attr_rb", v, 32'h1F);

    for (int i = 0; i < 13; i++) begin
      s = wr_cnt;
      push(vt[i].ch);
      tick(2);
      chk($sformatf("vec%0d_nwr", i), 32'(wr_cnt - s),
          {31'd0, vt[i].we});
      if (vt[i].we)
        chk($sformatf("vec%0d_cell", i), log_mem[13'(s)],
            {4'd0, vt[i].a, vt[i].d});
      rd(32'h8, v);
      chk($sformatf("vec%0d_cursor", i), v,
          cur(int'(vt[i].row), int'(vt[i].col)));
    end

    do_reset();
    s = wr_cnt;
    for (int i = 0; i < 90; i++) begin
      bus.a  = 32'h0;
      bus.d  = 32'h78;
      bus.we = 1'b1;
      tick(1);
    end
    bus.we = 1'b0;
    wait_idle(300);
    chk("wrap_nwr", 32'(wr_cnt - s), 32'd90);
    chk("wrap_last", log_mem[13'(s + 89)], {4'd0, 12'd89, 16'h0778});
    blanks = 0;
    for (int i = s; i < wr_cnt; i++)
      if (log_mem[13'(i)][7:0] == 8'h20) blanks++;
    chk("wrap_noclr", 32'(blanks), 32'd0);
    rd(32'h8, v); chk("wrap_cursor", v, cur(1, 0));

    s = wr_cnt;
    for (int i = 0; i < 29; i++) begin
      bus.a  = 32'h0;
      bus.d  = 32'h0A;
      bus.we = 1'b1;
      tick(1);
    end
    bus.we = 1'b0;
    wait_idle(300);
    chk("scr_nwr", 32'(wr_cnt - s), 32'd90);
    chk("scr_first", log_mem[13'(s)], {4'd0, 12'd0, 16'h0720});
    chk("scr_last", log_mem[13'(s + 89)], {4'd0, 12'd89, 16'h0720});
    chk("scr_sb", {27'd0, scroll_base}, 32'd1);
    rd(32'h8, v); chk("scr_cursor", v, cur(29, 0));

    s = wr_cnt;
    push(8'h41);
    tick(2);
    chk("scr_char", log_mem[13'(s)], {4'd0, 12'd0, 16'h0741});

    s = wr_cnt;
    push(8'h0A);
    tick(2);
    for (int i = 0; i < 17; i++) begin
      bus.a  = 32'h0;
      bus.d  = 32'h61 + 32'(i);
      bus.we = 1'b1;
      tick(1);
    end
    bus.we = 1'b0;
    rd(32'hC, v); chk("ovf_status", v, 32'h7);
    wr(32'hC, 32'h4);
    rd(32'hC, v); chk("ovf_clear", v, 32'h3);
    wait_idle(400);
    chk("ovf_nwr", 32'(wr_cnt - s), 32'd106);
    chk("ovf_clrrow", log_mem[13'(s)], {4'd0, 12'd90, 16'h0720});
    chk("ovf_first", log_mem[13'(s + 90)], {4'd0, 12'd90, 16'h0761});
    chk("ovf_lastq", log_mem[13'(s + 105)],
        {4'd0, 12'd105, 16'h0770});
    chk("ovf_sb", {27'd0, scroll_base}, 32'd2);
    rd(32'h8, v); chk("ovf_cursor", v, cur(29, 16));

    s = wr_cnt;
    push(8'h0C);
    tick(10);
    wr(32'h4, 32'h2E);
    wait_idle(3000);
    chk("ff_nwr", 32'(wr_cnt - s), 32'd2700);
    chk("ff_first", log_mem[13'(s)], {4'd0, 12'd0, 16'h0720});
    chk("ff_last", log_mem[13'(s + 2699)],
        {4'd0, 12'd2699, 16'h2E20});
    chk("ff_sb", {27'd0, scroll_base}, 32'd0);
    rd(32'h8, v); chk("ff_cursor", v, cur(0, 0));

    wr(32'h4, 32'h3C);
    push(8'h0C);
    tick(50);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mrst_we", {31'd0, vram_we}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_sb", {27'd0, scroll_base}, 32'd0);
    rd(32'h4, v); chk("mrst_attr", v, 32'h07);
    rd(32'hC, v); chk("mrst_status", v, 32'h0);
    s = wr_cnt;
    tick(5);
    chk("mrst_nowr", 32'(wr_cnt - s), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
